// File: rtl/aes256_inv_key_sched.sv
// AES-256 reverse key expansion: walks the schedule from w52..w59 back down to w0 and emits round keys 14..0.
// Optional build macro AES_INV_KS_ZEROIZE_EN clears the key window and round counter once the walk completes.

module aes_inv_ks_sbox (
    input  logic [7:0] a,
    output logic [7:0] y
);
    localparam logic [0:255][7:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    assign y = SBOX[a];
endmodule

module aes256_inv_key_sched (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [255:0] last_key,
    input  logic         key_ready,
    output logic [127:0] round_key,
    output logic         key_valid,
    output logic [3:0]   key_index,
    output logic         busy,
    output logic         done
);
    typedef enum logic [1:0] {IDLE, EMIT, GEN, DONE} state_t;

    state_t           state;
    logic [0:7][31:0] win;      // win[0] = w[j] (oldest word), win[7] = w[j+7]
    logic [3:0]       r;
    logic [1:0]       gen_cnt;

    logic [5:0]       i_idx;
    logic [31:0]      t_in;
    logic [31:0]      t_sel;
    logic [31:0]      t_sub;
    logic [31:0]      t_out;
    logic [31:0]      new_w;
    logic [7:0]       rcon;

    // During GEN for round r, j runs 4(r+1) down to 4r+1, so i = j+7 = 4r+11-gen_cnt.
    assign i_idx = {r, 2'b00} + 6'd11 - {4'b0000, gen_cnt};
    assign t_in  = win[6];
    assign t_sel = (i_idx[2:0] == 3'd0) ? {t_in[23:0], t_in[31:24]} : t_in;
    assign rcon  = 8'h01 << (i_idx[5:3] - 3'd1);

    genvar b;
    generate
        for (b = 0; b < 4; b++) begin : g_sbox
            aes_inv_ks_sbox u_sbox (
                .a (t_sel[8*b +: 8]),
                .y (t_sub[8*b +: 8])
            );
        end
    endgenerate

    always_comb begin
        t_out = t_in;
        case (i_idx[2:0])
            3'd0:    t_out = t_sub ^ {rcon, 24'h000000};
            3'd4:    t_out = t_sub;
            default: t_out = t_in;
        endcase
    end

    // Forward rule w[i] = w[i-8] ^ T(w[i-1]) solved for w[i-8].
    assign new_w = win[7] ^ t_out;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            win     <= '0;
            r       <= '0;
            gen_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        win   <= last_key;
                        r     <= 4'd14;
                        state <= EMIT;
                    end
                end
                EMIT: begin
                    if (key_ready) begin
                        if (r == 4'd0) begin
                            state <= DONE;
                        end else if (r == 4'd14) begin
                            // Round 13 already sits in the loaded window's upper half.
                            r <= 4'd13;
                        end else begin
                            r       <= r - 4'd1;
                            gen_cnt <= 2'd0;
                            state   <= GEN;
                        end
                    end
                end
                GEN: begin
                    win     <= {new_w, win[0:6]};
                    gen_cnt <= gen_cnt + 2'd1;
                    if (gen_cnt == 2'd3)
                        state <= EMIT;
                end
                DONE: begin
                    state <= IDLE;
`ifdef AES_INV_KS_ZEROIZE_EN
                    win   <= '0;
                    r     <= '0;
`endif
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign key_valid = (state == EMIT);
    assign busy      = (state != IDLE);
    assign done      = (state == DONE);
    assign key_index = key_valid ? r : 4'd0;
    assign round_key = !key_valid   ? 128'd0 :
                       (r == 4'd14) ? {win[4], win[5], win[6], win[7]} :
                                      {win[0], win[1], win[2], win[3]};
endmodule

// File: tb/tb_aes256_inv_key_sched.sv
// Directed and model-based checks for aes256_inv_key_sched: timing, stalls, ignored restarts, reset abort.
module tb_aes256_inv_key_sched;
    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [255:0] last_key;
    logic         key_ready;
    logic [127:0] round_key;
    logic         key_valid;
    logic [3:0]   key_index;
    logic         busy;
    logic         done;

    always #5 clk = ~clk;

    aes256_inv_key_sched dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .last_key  (last_key),
        .key_ready (key_ready),
        .round_key (round_key),
        .key_valid (key_valid),
        .key_index (key_index),
        .busy      (busy),
        .done      (done)
    );

    localparam logic [255:0] KEY = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [255:0] LK  = {128'h4e5a6699a9f24fe07e572baacdf8cdea, 128'h24fc79ccbf0979e9371ac23c6d68de36};
    localparam logic [127:0] R14 = 128'h24fc79ccbf0979e9371ac23c6d68de36;
    localparam logic [127:0] R13 = 128'h4e5a6699a9f24fe07e572baacdf8cdea;
    localparam logic [127:0] R1  = 128'h101112131415161718191a1b1c1d1e1f;
    localparam logic [127:0] R0  = 128'h000102030405060708090a0b0c0d0e0f;

    localparam logic [0:255][7:0] SB = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    typedef struct {
        string name;
        int    stall_idx;
        int    stall_len;
        int    dup_cyc;
        int    exp_r0_cyc;
        int    exp_done_cyc;
    } vec_t;

    vec_t         vecs [0:4];
    int           checks = 0;
    int           errors = 0;
    logic [31:0]  ref_w  [0:59];
    logic [127:0] em_key [0:15];
    int           em_idx [0:15];
    int           em_cyc [0:15];
    int           em_cnt, done_cyc, done_cnt, viol, stall_bad;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] subw(input logic [31:0] x);
        return {SB[x[31:24]], SB[x[23:16]], SB[x[15:8]], SB[x[7:0]]};
    endfunction

    // Reference forward AES-256 key expansion.
    task automatic expand(input logic [255:0] k);
        logic [31:0] t;
        for (int i = 0; i < 8; i++) ref_w[i] = k[255-32*i -: 32];
        for (int i = 8; i < 60; i++) begin
            t = ref_w[i-1];
            if (i % 8 == 0)      t = subw({t[23:0], t[31:24]}) ^ {8'(8'h01 << (i/8 - 1)), 24'h0};
            else if (i % 8 == 4) t = subw(t);
            ref_w[i] = ref_w[i-8] ^ t;
        end
    endtask

    // One full walk; cycle 0 is the start cycle, outputs sampled on the falling edge.
    task automatic run_seq(input logic [255:0] lk, input int stall_idx, input int stall_len, input int dup_cyc);
        int           left;
        logic [127:0] held;
        em_cnt = 0; done_cyc = -1; done_cnt = 0; viol = 0; stall_bad = 0;
        left = stall_len; held = '0;
        @(negedge clk);
        start = 1'b1; last_key = lk; key_ready = 1'b1;
        for (int c = 1; c <= 120; c++) begin
            @(negedge clk);
            start    = (c == dup_cyc);
            last_key = ~lk;
            if (done_cyc >= 0) begin
                if (busy || key_valid || done || round_key != 0) viol++;
                break;
            end
            if (key_valid && int'(key_index) == stall_idx && left > 0) begin
                key_ready = 1'b0;
                if (left == stall_len) held = round_key;
                else if (round_key !== held) stall_bad++;
                left--;
            end else begin
                key_ready = 1'b1;
                if (key_valid && stall_len > 0 && int'(key_index) == stall_idx && round_key !== held) stall_bad++;
            end
            if (key_valid && key_ready) begin
                if (em_cnt < 16) begin
                    em_key[em_cnt] = round_key;
                    em_idx[em_cnt] = int'(key_index);
                    em_cyc[em_cnt] = c;
                end
                em_cnt++;
            end
            if (!key_valid && (key_index != 0 || round_key != 0)) viol++;
            if (!busy) viol++;
            if (done) begin
                done_cnt++;
                done_cyc = c;
                if (key_valid) viol++;
            end
        end
        start = 1'b0; key_ready = 1'b1;
    endtask

    task automatic check_window(input string name, input logic [255:0] key);
`ifdef AES_INV_KS_ZEROIZE_EN
        check({name, "_win"}, dut.win, 256'd0);
`else
        check({name, "_win"}, dut.win, key);
`endif
    endtask

    initial begin
        int   bad;
        int   dn;
        logic [255:0] rk;

        vecs[0] = '{"nominal",   -1, 0, -1, 67, 68};
        vecs[1] = '{"stall_r12", 12, 3, -1, 70, 71};
        vecs[2] = '{"dup_start", -1, 0, 10, 67, 68};
        vecs[3] = '{"stall_r0",   0, 2, -1, 69, 70};
        vecs[4] = '{"stall_r14", 14, 1, -1, 68, 69};

        rst = 1'b1; start = 1'b0; key_ready = 1'b1; last_key = '0;
        repeat (2) @(negedge clk);
        check("reset_outputs", {round_key, key_valid, key_index, busy, done}, '0);
        rst = 1'b0;
        @(negedge clk);
        check("idle_outputs", {round_key, key_valid, key_index, busy, done}, '0);

        for (int v = 0; v < 5; v++) begin
            run_seq(LK, vecs[v].stall_idx, vecs[v].stall_len, vecs[v].dup_cyc);
            check({vecs[v].name, "_count"}, 256'(em_cnt), 256'd15);
            check({vecs[v].name, "_done_cyc"}, 256'(done_cyc), 256'(vecs[v].exp_done_cyc));
            check({vecs[v].name, "_done_pulses"}, 256'(done_cnt), 256'd1);
            check({vecs[v].name, "_protocol"}, 256'(viol), 256'd0);
            check({vecs[v].name, "_stall_hold"}, 256'(stall_bad), 256'd0);
            if (em_cnt == 15) begin
                check({vecs[v].name, "_r0_cyc"}, 256'(em_cyc[14]), 256'(vecs[v].exp_r0_cyc));
                check({vecs[v].name, "_r14"}, em_key[0], R14);
                check({vecs[v].name, "_r13"}, em_key[1], R13);
                check({vecs[v].name, "_r1"}, em_key[13], R1);
                check({vecs[v].name, "_r0"}, em_key[14], R0);
                bad = 0;
                for (int p = 0; p < 15; p++) begin
                    int k;
                    int e;
                    k = 14 - p;
                    e = (k == 14) ? 1 : (k == 13) ? 2 : 67 - 5*k;
                    if (vecs[v].stall_idx >= k) e += vecs[v].stall_len;
                    if (em_idx[p] != k || em_cyc[p] != e) bad++;
                end
                check({vecs[v].name, "_order_timing"}, 256'(bad), 256'd0);
            end
            check_window(vecs[v].name, KEY);
        end

        // Reset in the middle of a walk, then a clean rerun.
        @(negedge clk);
        start = 1'b1; last_key = LK; key_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (29) @(negedge clk);
        check("busy_before_rst", 256'(busy), 256'd1);
        rst = 1'b1;
        #1;
        check("rst_async_outputs", {round_key, key_valid, key_index, busy, done}, '0);
        dn = 0;
        repeat (3) begin
            @(negedge clk);
            if (done || busy || key_valid) dn++;
        end
        check("rst_no_done", 256'(dn), 256'd0);
        rst = 1'b0;
        run_seq(LK, -1, 0, -1);
        check("rerun_count", 256'(em_cnt), 256'd15);
        check("rerun_done_cyc", 256'(done_cyc), 256'd68);
        if (em_cnt == 15) begin
            check("rerun_r14", em_key[0], R14);
            check("rerun_r0", em_key[14], R0);
        end

        // Cross-check against forward expansion of random keys.
        for (int n = 0; n < 8; n++) begin
            rk = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
            expand(rk);
            run_seq({ref_w[52], ref_w[53], ref_w[54], ref_w[55], ref_w[56], ref_w[57], ref_w[58], ref_w[59]}, -1, 0, -1);
            check($sformatf("rnd%0d_count", n), 256'(em_cnt), 256'd15);
            check($sformatf("rnd%0d_done_cyc", n), 256'(done_cyc), 256'd68);
            if (em_cnt == 15) begin
                for (int p = 0; p < 15; p++) begin
                    int k;
                    k = 14 - p;
                    check($sformatf("rnd%0d_r%0d", n, k),
                          {em_key[p], 128'(em_idx[p])},
                          {ref_w[4*k], ref_w[4*k+1], ref_w[4*k+2], ref_w[4*k+3], 128'(k)});
                end
            end
            check_window($sformatf("rnd%0d", n), rk);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/aes256_inv_key_sched.md
AES256_INV_KEY_SCHED -- requirements
Module: aes256_inv_key_sched

Interface
REQ-001 SHALL have port clk, input, 1, sole clock; all state on rising edge.
REQ-002 SHALL have port rst, input, 1, reset; asynchronous, active-high.
REQ-003 SHALL have port start, input, 1, single-cycle request to begin reverse expansion; sampled only in IDLE.
REQ-004 SHALL have port last_key, input, 256, words w52..w59 of the AES-256 schedule; [255:224]=w52 ... [31:0]=w59; sampled with start.
REQ-005 SHALL have port key_ready, input, 1, downstream accepts round_key when high with key_valid.
REQ-006 SHALL have port round_key, output, 128, round key r = w[4r]..w[4r+3], [127:96]=w[4r].
REQ-007 SHALL have port key_valid, output, 1, round_key/key_index valid.
REQ-008 SHALL have port key_index, output, 4, round number r of round_key (14 down to 0).
REQ-009 SHALL have port busy, output, 1, high in every state except IDLE.
REQ-010 SHALL have port done, output, 1, one-cycle pulse after round 0 is accepted.

Function
REQ-011 SHALL hold an 8-word window W = w[j..j+7]; load j=52 from last_key on start.
REQ-012 SHALL generate one word per GEN cycle: w[j-1] = w[j+7] XOR T(w[j+6]), then shift window so j decrements by 1.
REQ-013 T(x) for i=j+7: i%8==0 -> SubWord(RotWord(x)) XOR {Rcon[i/8],24'h0}; i%8==4 -> SubWord(x); else x.
REQ-014 Rcon[1..7] SHALL be 01,02,04,08,10,20,40; RotWord = {x[23:0],x[31:24]}; SubWord = forward AES S-box per byte, 4 S-box instances.
REQ-015 FSM states SHALL be IDLE, EMIT, GEN, DONE.
REQ-016 IDLE: start=1 -> load W, r=14, go EMIT next cycle; start=0 -> stay.
REQ-017 EMIT: key_valid=1; round_key = W low 4 words if r==14, else W high 4 words (w[j..j+3], j=4r).
REQ-018 EMIT with key_ready=0 SHALL hold round_key, key_index, W stable (stall, no timeout).
REQ-019 EMIT with key_ready=1: r==0 -> DONE; r==14 -> r=13, stay EMIT; else r=r-1, GEN with 2-bit counter cleared.
REQ-020 GEN: exactly 4 cycles, key_valid=0, then EMIT.
REQ-021 DONE: done=1 for one cycle, then IDLE.
REQ-022 start asserted while busy SHALL be ignored.
REQ-023 With key_ready tied high: start cycle 0 -> r14 valid cycle 1, r13 cycle 2, r12 cycle 7, r(k) cycle 67-5k for k<=12, r0 cycle 67, done cycle 68.
REQ-024 key_valid SHALL never be high outside EMIT; key_index SHALL equal r in EMIT, 0 elsewhere.

Reset
REQ-025 rst=1 SHALL asynchronously force IDLE, W=0, r=0, GEN counter=0.
REQ-026 During reset: round_key=0, key_valid=0, key_index=0, busy=0, done=0.
REQ-027 rst mid-operation SHALL abort without a done pulse; a new start after release SHALL run from the beginning.

Configuration
REQ-028 Macro AES_INV_KS_ZEROIZE_EN: defined -> W and r cleared to 0 in the DONE cycle, so round_key reads 0 in IDLE after completion.
REQ-029 Undefined -> W retains final window (w0..w7) after DONE; round_key still driven 0 whenever key_valid=0.
REQ-030 Cycle timing of REQ-023 SHALL be identical with or without the macro.

Verification
REQ-031 last_key = schedule words w52..w59 of key 000102..1f, key_ready=1 -> r14=24fc79ccbf0979e9371ac23c6d68de36, r13=4e5a6699a9f24fe07e572baacdf8cdea, r1=101112131415161718191a1b1c1d1e1f, r0=000102030405060708090a0b0c0d0e0f.
REQ-032 Same stimulus, key_ready low 3 cycles at r12 -> r12 held stable, r0 at cycle 70, done at 71.
REQ-033 rst pulsed at cycle 30 -> all outputs 0 immediately, no done; restart reproduces REQ-031 sequence.
REQ-034 start pulsed again at cycle 10 -> ignored, sequence and timing unchanged.
REQ-035 Cross-check: 15 emitted keys equal a reference forward AES-256 expansion of 8 random keys, indices 14..0 in order.
REQ-036 AES_INV_KS_ZEROIZE_EN defined -> internal W reads all-zero the cycle after done; undefined -> W = w0..w7.
